mod_inv_div: RTL

// Parametrised modular inverse / modular division unit for the ECDSA datapath.
// - Computes X = num * A^-1 mod p with a binary extended-Euclid iteration, one step per cycle.
// - mode=0 gives the plain inverse (num forced to 1). mode=1 gives division, e.g. s^-1*z in one pass.
// - Uses a valid/ready handshake on both sides and reports operand and non-invertibility errors.
// - Sits between the scalar arithmetic blocks and the point-arithmetic sequencer.

---
 rtl/mod_arith_pkg.sv | 20 ++
 rtl/mod_halve.sv | 16 +
 rtl/mod_inv_div.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/mod_arith_pkg.sv
// Shared types and codes for the modular arithmetic blocks.
// Used by the inverse/division unit and its helpers.
package mod_arith_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [1:0] ERR_OK             = 2'd0;
    localparam logic [1:0] ERR_BAD_MOD        = 2'd1;
    localparam logic [1:0] ERR_BAD_OPERAND    = 2'd2;
    localparam logic [1:0] ERR_NOT_INVERTIBLE = 2'd3;

    localparam logic MODE_INV = 1'b0;
    localparam logic MODE_DIV = 1'b1;

endpackage

// File: rtl/mod_halve.sv
// Modular halving: (v + v[0]*p) >> 1 for odd p and v < p.
// Written as v/2 + (p+1)/2 so no N+1-bit carry is needed.
module mod_halve #(
    parameter int N = 256
) (
    input  logic [N-1:0] v_i,
    input  logic [N-1:0] p_i,
    output logic [N-1:0] h_o
);

    logic [N-1:0] p_half_up;

    assign p_half_up = (p_i >> 1) + N'(1);
    assign h_o       = (v_i >> 1) + (v_i[0] ? p_half_up : '0);

endmodule

// File: rtl/mod_inv_div.sv
// Modular inverse / division x = num * a^-1 mod p.
// Binary extended Euclid, one step per clock.
import mod_arith_pkg::*;

module mod_inv_div #(
    parameter int N     = 256,
    parameter int CNT_W = $clog2(4*N+8)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mode,
    input  logic [N-1:0]     p,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     num,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     x,
    output logic [1:0]       err,
    output logic [CNT_W-1:0] iter
);

    state_e           state_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [N-1:0]     x_q;
    logic [1:0]       err_q;
    logic [CNT_W-1:0] iter_q;

    logic             mode_q;
    logic [N-1:0]     p_q;
    logic [N-1:0]     y_q;
    logic [N-1:0]     d_q;
    logic [N-1:0]     b_q;
    logic [N-1:0]     xw_q;
    logic [CNT_W-1:0] cnt_q;

    logic [N-1:0]     y_d;
    logic [N-1:0]     d_d;
    logic [N-1:0]     b_d;
    logic [N-1:0]     xw_d;

    logic [N-1:0]     b_half;
    logic [N-1:0]     x_half;
    logic [N:0]       bx_diff;
    logic [N:0]       xb_diff;
    logic [N-1:0]     b_minus_x;
    logic [N-1:0]     x_minus_b;

    logic             bad_mod;
    logic             bad_opnd;

    mod_halve #(.N(N)) u_halve_b (
        .v_i (b_q),
        .p_i (p_q),
        .h_o (b_half)
    );

    mod_halve #(.N(N)) u_halve_x (
        .v_i (xw_q),
        .p_i (p_q),
        .h_o (x_half)
    );

    // Top bit of the N+1-bit difference is the borrow; add p back on borrow.
    assign bx_diff   = {1'b0, b_q} - {1'b0, xw_q};
    assign xb_diff   = {1'b0, xw_q} - {1'b0, b_q};
    assign b_minus_x = bx_diff[N-1:0] + (bx_diff[N] ? p_q : '0);
    assign x_minus_b = xb_diff[N-1:0] + (xb_diff[N] ? p_q : '0);

    assign bad_mod  = !p_q[0] || (p_q < N'(3));
    assign bad_opnd = (y_q == '0) || (y_q >= p_q)
                   || ((mode_q == MODE_DIV) && (b_q >= p_q));

    always_comb begin
        y_d  = y_q;
        d_d  = d_q;
        b_d  = b_q;
        xw_d = xw_q;
        if (!y_q[0]) begin
            y_d = y_q >> 1;
            b_d = b_half;
        end else if (!d_q[0]) begin
            d_d  = d_q >> 1;
            xw_d = x_half;
        end else if (y_q >= d_q) begin
            y_d = y_q - d_q;
            b_d = b_minus_x;
        end else begin
            d_d  = d_q - y_q;
            xw_d = x_minus_b;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            x_q         <= '0;
            err_q       <= ERR_OK;
            iter_q      <= '0;
            mode_q      <= MODE_INV;
            p_q         <= '0;
            y_q         <= '0;
            d_q         <= '0;
            b_q         <= '0;
            xw_q        <= '0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        mode_q     <= mode;
                        p_q        <= p;
                        y_q        <= a;
                        b_q        <= (mode == MODE_DIV) ? num : N'(1);
                        in_ready_q <= 1'b0;
                        state_q    <= CHECK;
                    end
                end
                CHECK: begin
                    d_q   <= p_q;
                    xw_q  <= '0;
                    cnt_q <= '0;
                    if (bad_mod || bad_opnd) begin
                        x_q         <= '0;
                        err_q       <= bad_mod ? ERR_BAD_MOD
                                               : ERR_BAD_OPERAND;
                        iter_q      <= '0;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (y_q == '0) begin
                        // D now holds gcd(a, p); only gcd 1 yields a result.
                        if (d_q == N'(1)) begin
                            x_q   <= xw_q;
                            err_q <= ERR_OK;
                        end else begin
                            x_q   <= '0;
                            err_q <= ERR_NOT_INVERTIBLE;
                        end
                        iter_q      <= cnt_q + 1'b1;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        y_q  <= y_d;
                        d_q  <= d_d;
                        b_q  <= b_d;
                        xw_q <= xw_d;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign x         = x_q;
    assign err       = err_q;
    assign iter      = iter_q;

endmodule
